// File: rtl/seq_mul.sv
// seq_mul: multi-cycle shift-add multiplier for the MULT/MULTU path.
//
// An operation takes WIDTH+2 cycles from accepted start to the next accepted
// start. The multiplier first converts both operands to unsigned magnitudes.
// It then runs WIDTH shift-add iterations. Finally it negates the product if
// the operand signs differed.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      request, sampled only while idle
//   sign_flag  1 = signed (two's complement), 0 = unsigned; sampled with start
//   A, B       multiplicand / multiplier; sampled with start
//   busy       high while an operation is in progress
//   done       one-cycle pulse; HI/LO valid from this cycle
//   HI, LO     upper / lower WIDTH bits of the 2*WIDTH-bit product
module seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_flag,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic               msb_diff_q, msb_diff_d;    // operand MSBs differ
  logic [WIDTH-1:0]   mcand_q, mcand_d;          // |A|
  logic [WIDTH-1:0]   mplier_q, mplier_d;        // |B|, consumed LSB first
  logic [2*WIDTH:0]   acc_q, acc_d;              // one spare bit for the add carry
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_sum;
  logic [2*WIDTH-1:0] result;

  // The magnitude of the most negative value, 2^(WIDTH-1), still fits in an
  // unsigned WIDTH-bit register, so negation never overflows here.
  function automatic logic [WIDTH-1:0] magnitude(input logic is_signed,
                                                 input logic [WIDTH-1:0] v);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    sign_d     = sign_q;
    msb_diff_d = msb_diff_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    upper_sum  = '0;
    acc_sum    = '0;
    result     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d     = sign_flag;
          msb_diff_d = A[WIDTH-1] ^ B[WIDTH-1];
          mcand_d    = magnitude(sign_flag, A);
          mplier_d   = magnitude(sign_flag, B);
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = ST_CALC;
        end
      end

      ST_CALC: begin
        // Add into the upper half, then shift the whole accumulator right.
        // After WIDTH iterations the product is in acc[2*WIDTH-1:0].
        upper_sum = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_sum   = {upper_sum, acc_q[WIDTH-1:0]};
        acc_d     = {1'b0, acc_sum[2*WIDTH:1]};
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        result  = (sign_q && msb_diff_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        hi_d    = result[2*WIDTH-1:WIDTH];
        lo_d    = result[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // busy is registered from the next state, so it drops in the done cycle.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      msb_diff_q <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together
      // from the values computed before this edge.
      state_q    <= state_d;
      sign_q     <= sign_d;
      msb_diff_q <= msb_diff_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_seq_mul.sv
// Testbench for seq_mul. It runs three instances at WIDTH = 32, 16 and 8.
// Every cycle, a cycle-accurate scoreboard predicts busy, done, HI and LO
// for each instance.
module tb_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v [3];
  logic        sign_v  [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic [31:0] drv_hi  [3];
  logic [31:0] drv_lo  [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [31:0] hi_v    [3];
  logic [31:0] lo_v    [3];
  logic [15:0] hi16, lo16;
  logic [7:0]  hi8, lo8;

  seq_mul #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sign_flag(sign_v[0]),
    .A(a_v[0]), .B(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .HI(hi_v[0]), .LO(lo_v[0]));

  seq_mul #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sign_flag(sign_v[1]),
    .A(a_v[1][15:0]), .B(b_v[1][15:0]), .busy(busy_v[1]), .done(done_v[1]),
    .HI(hi16), .LO(lo16));

  seq_mul #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sign_flag(sign_v[2]),
    .A(a_v[2][7:0]), .B(b_v[2][7:0]), .busy(busy_v[2]), .done(done_v[2]),
    .HI(hi8), .LO(lo8));

  assign hi_v[1] = {16'h0, hi16};
  assign lo_v[1] = {16'h0, lo16};
  assign hi_v[2] = {24'h0, hi8};
  assign lo_v[2] = {24'h0, lo8};

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;   // edge index after which done must be high
  } exp_t;

  typedef struct {
    int          k;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t        sb [3][$];
  int          cyc = 0;
  logic        samp_rst;
  logic        samp_start [3];
  logic [31:0] samp_hi [3];
  logic [31:0] samp_lo [3];
  logic [31:0] last_hi [3];
  logic [31:0] last_lo [3];
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        vecs [10];

  function automatic int wid(input int k);
    return (k == 0) ? 32 : (k == 1) ? 16 : 8;
  endfunction

  // Golden product: sign-extend to 64 bits and multiply. The low 64 bits of
  // the product are exact, and the result is cut down to 2*w bits.
  function automatic logic [63:0] golden(input int w, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ax, bx, p, hi64;
    mask = (64'd1 << w) - 64'd1;
    ax   = {32'h0, a} & mask;
    bx   = {32'h0, b} & mask;
    if (s && a[w-1]) ax = ax | ~mask;
    if (s && b[w-1]) bx = bx | ~mask;
    p    = ax * bx;
    hi64 = (p >> w) & mask;
    return {hi64[31:0], p[31:0] & mask[31:0]};
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record what each DUT sampled at this edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    samp_rst = rst;
    for (int k = 0; k < 3; k++) begin
      samp_start[k] = start_v[k];
      samp_hi[k]    = drv_hi[k];
      samp_lo[k]    = drv_lo[k];
    end
  end

  // Advance the model by the edge that just happened, then compare outputs.
  always @(negedge clk) begin
    logic eb, ed;
    if (samp_rst === 1'b1) begin
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
        sb[k].delete();
        last_hi[k] = '0;
        last_lo[k] = '0;
      end
    end else if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        if (samp_start[k] && sb[k].size() == 0)
          sb[k].push_back('{samp_hi[k], samp_lo[k], cyc + wid(k) + 1});
      end
    end
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        eb = 1'b0;
        ed = 1'b0;
        if (sb[k].size() != 0) begin
          if (cyc == sb[k][0].due) begin
            ed = 1'b1;
            last_hi[k] = sb[k][0].hi;
            last_lo[k] = sb[k][0].lo;
            void'(sb[k].pop_front());
          end else begin
            eb = 1'b1;
          end
        end
        check($sformatf("w%0d busy/done/HI/LO cycle %0d", wid(k), cyc),
              {busy_v[k], done_v[k], hi_v[k], lo_v[k]},
              {eb, ed, last_hi[k], last_lo[k]});
      end
    end
  end

  task automatic set_op(input int k, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    start_v[k] = 1'b1;
    sign_v[k]  = s;
    a_v[k]     = a;
    b_v[k]     = b;
    drv_hi[k]  = eh;
    drv_lo[k]  = el;
  endtask

  // Called at a negedge; start is high for exactly one rising edge.
  task automatic issue(input int k, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    set_op(k, s, a, b, eh, el);
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic issue_g(input int k, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] g;
    g = golden(wid(k), s, a, b);
    issue(k, s, a, b, g[63:32], g[31:0]);
  endtask

  task automatic wait_idle(input int k);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (sb[k].size() != 0 && i < 200);
    check($sformatf("w%0d completion within bound", wid(k)), 66'(sb[k].size()), 66'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_8080;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] g;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2] = '{0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[3] = '{0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{2, 1'b1, 32'h0000_0080, 32'h0000_0080, 32'h0000_0040, 32'h0000_0000};
    vecs[5] = '{0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{1, 1'b1, 32'h0000_8000, 32'h0000_7FFF, 32'h0000_C000, 32'h0000_8000};
    vecs[7] = '{0, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{2, 1'b0, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FE, 32'h0000_0001};
    vecs[9] = '{1, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0001};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      sign_v[k]  = 1'b0;
      a_v[k]     = '0;
      b_v[k]     = '0;
      drv_hi[k]  = '0;
      drv_lo[k]  = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed products.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(vecs[i].k, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      wait_idle(vecs[i].k);
    end

    // Operands change and start pulses while busy: both must be ignored.
    @(negedge clk);
    issue(0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    repeat (5) @(negedge clk);
    issue(0, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0, 32'h0);
    wait_idle(0);
    repeat (40) @(negedge clk);

    // Back-to-back: the next start is driven in the done cycle.
    @(negedge clk);
    issue(0, 1'b0, 32'd3, 32'd5, 32'h0, 32'd15);
    repeat (33) @(negedge clk);
    set_op(0, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 32'h0);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);

    // start held high: the 8-bit instance restarts on every idle cycle.
    @(negedge clk);
    g = golden(8, 1'b1, 32'hF3, 32'h05);
    set_op(2, 1'b1, 32'hF3, 32'h05, g[63:32], g[31:0]);
    repeat (25) @(negedge clk);
    start_v[2] = 1'b0;
    wait_idle(2);

    // Reset in the middle of CALC aborts the operation.
    @(negedge clk);
    issue_g(0, 1'b0, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue_g(0, 1'b1, 32'hFFFF_FF00, 32'h0000_0100);
    wait_idle(0);

    // Random operations on all three widths in parallel.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        ra = pick();
        rb = pick();
        rs = 1'($urandom_range(0, 1));
        g  = golden(wid(k), rs, ra, rb);
        set_op(k, rs, ra, rb, g[63:32], g[31:0]);
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
      wait_idle(0);
      wait_idle(1);
      wait_idle(2);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
